// File: rtl/comparator_pkg.sv
// ----------------------------------------------------------------------------
// comparator_pkg
// Shared types and helpers for the serial compare path.
//   cmp_state_t : FSM states of the serial comparator
//   cmp_cnt_w() : bit-counter width for a given operand size
// ----------------------------------------------------------------------------
package comparator_pkg;

    typedef enum logic [1:0] {
        CMP_IDLE  = 2'd0,
        CMP_SHIFT = 2'd1,
        CMP_DONE  = 2'd2
    } cmp_state_t;

    // Counter only has to reach SIZE-1; guard the degenerate case so the
    // width is never zero.
    function automatic int cmp_cnt_w(input int size);
        return (size < 2) ? 1 : $clog2(size);
    endfunction

endpackage : comparator_pkg

// File: rtl/serial_signed_comparator_if.sv
// ----------------------------------------------------------------------------
// serial_signed_comparator_if
// Operand and result handshakes of the serial signed comparator.
//   in_valid/in_ready  : operand transfer (a, b)
//   out_valid/out_ready: result transfer (is_a_greater, equal)
// master: operand source / result consumer. slave: the comparator.
// ----------------------------------------------------------------------------
interface serial_signed_comparator_if #(
    parameter int SIZE = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic            is_a_greater;
    logic            equal;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, is_a_greater, equal
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, is_a_greater, equal
    );
endinterface : serial_signed_comparator_if

// File: rtl/compare_bit_step.sv
// ----------------------------------------------------------------------------
// compare_bit_step
// One LSB-first step of a signed magnitude compare. A differing bit
// overrides whatever less significant bits decided; on the sign bit the
// sense is inverted because a set sign bit means the smaller value.
//   i_a_bit, i_b_bit : current operand bits
//   i_is_sign        : current bit is the sign bit
//   i_gt, i_eq       : running result so far
//   o_gt, o_eq       : running result including this bit
// ----------------------------------------------------------------------------
module compare_bit_step (
    input  logic i_a_bit,
    input  logic i_b_bit,
    input  logic i_is_sign,
    input  logic i_gt,
    input  logic i_eq,
    output logic o_gt,
    output logic o_eq
);
    always_comb begin
        // NOTE: both outputs get a default before any branch, so no path
        // leaves them unassigned and no latch is inferred.
        o_gt = i_gt;
        o_eq = i_eq;
        if (i_a_bit != i_b_bit) begin
            o_gt = i_is_sign ? ~i_a_bit : i_a_bit;
            o_eq = 1'b0;
        end
    end
endmodule : compare_bit_step

// File: rtl/serial_signed_comparator.sv
// ----------------------------------------------------------------------------
// serial_signed_comparator
// Bit-serial, LSB-first signed two's-complement comparator. Operands are
// captured on the input handshake, scanned one bit per clock over SIZE
// cycles, and the flags are held on the output handshake until consumed.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of serial_signed_comparator_if
//                (in_valid/in_ready/a/b, out_valid/out_ready/
//                 is_a_greater/equal)
// All outputs come from flops; nothing depends combinationally on
// in_valid or out_ready.
// ----------------------------------------------------------------------------
module serial_signed_comparator
    import comparator_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_signed_comparator_if.slave   bus
);
    localparam int CNT_W = cmp_cnt_w(SIZE);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIZE - 1);

    cmp_state_t       r_state;
    cmp_state_t       w_state_next;
    logic [SIZE-1:0]  r_a_sr;
    logic [SIZE-1:0]  r_b_sr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_gt;
    logic             r_eq;
    logic             w_last;
    logic             w_gt_step;
    logic             w_eq_step;

    assign w_last = (r_cnt == LAST_BIT);

    compare_bit_step u_step (
        .i_a_bit   (r_a_sr[0]),
        .i_b_bit   (r_b_sr[0]),
        .i_is_sign (w_last),
        .i_gt      (r_gt),
        .i_eq      (r_eq),
        .o_gt      (w_gt_step),
        .o_eq      (w_eq_step)
    );

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked blocks use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) r_state <= CMP_IDLE;
        else        r_state <= w_state_next;
    end

    // ---------------- FSM next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CMP_IDLE:  if (bus.in_valid)  w_state_next = CMP_SHIFT;
            CMP_SHIFT: if (w_last)        w_state_next = CMP_DONE;
            CMP_DONE:  if (bus.out_ready) w_state_next = CMP_IDLE;
            default:                      w_state_next = CMP_IDLE;
        endcase
    end

    // ---------------- Datapath: shift registers, counter, flags ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the shift registers are ordinary flops rather than a RAM, so
        // they can and do take the asynchronous reset with everything else.
        if (!rst_n) begin
            r_a_sr <= '0;
            r_b_sr <= '0;
            r_cnt  <= '0;
            r_gt   <= 1'b0;
            r_eq   <= 1'b0;
        end else begin
            case (r_state)
                CMP_IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sr <= bus.a;
                        r_b_sr <= bus.b;
                        r_cnt  <= '0;
                        r_gt   <= 1'b0;
                        r_eq   <= 1'b1;
                    end
                end
                CMP_SHIFT: begin
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_gt   <= w_gt_step;
                    r_eq   <= w_eq_step;
                    // Hold at SIZE-1 on the sign step so the counter never wraps.
                    if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // ---------------- Outputs ----------------
    assign bus.in_ready     = (r_state == CMP_IDLE);
    assign bus.out_valid    = (r_state == CMP_DONE);
    assign bus.is_a_greater = r_gt;
    assign bus.equal        = r_eq;

endmodule : serial_signed_comparator

// File: tb/tb_serial_signed_comparator.sv
// ----------------------------------------------------------------------------
// tb_serial_signed_comparator
// Scoreboard bench: the driver pushes the expected flags (signed compare of
// the operands) when an operand transfer happens; a monitor pops and
// compares whenever a result transfer happens.
// ----------------------------------------------------------------------------
module tb_serial_signed_comparator;
    localparam int SIZE = 8;

    typedef struct packed {
        logic gt;
        logic eq;
    } exp_t;

    logic clk;
    logic rst_n;

    serial_signed_comparator_if #(.SIZE(SIZE)) bus ();

    serial_signed_comparator #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_vec;
    int   n_cmp;
    int   n_err;
    int   rdy_mode;   // 0: always ready, 1: random stalls, 2: held low

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain signed arithmetic on the whole operands.
    function automatic exp_t model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        exp_t e;
        e.gt = ($signed(a) > $signed(b));
        e.eq = (a == b);
        return e;
    endfunction

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        int waited;
        waited       = 0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.in_ready && waited < 200);
        if (!bus.in_ready) begin
            check("accept_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            exp_q.push_back(model(a, b));
            n_vec++;
        end
    endtask

    // out_ready generator: the only driver of out_ready.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(9) < 7);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard: a result transfers at the next posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                check("eq_implies_not_gt", 32'(bus.equal & bus.is_a_greater), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("is_a_greater", 32'(bus.is_a_greater), 32'(e.gt));
                    check("equal",        32'(bus.equal),        32'(e.eq));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    logic [SIZE-1:0] sign_a [5] = '{8'hFF, 8'h7F, 8'h80, 8'hA5, 8'hFE};
    logic [SIZE-1:0] sign_b [5] = '{8'h01, 8'h80, 8'h7F, 8'hA5, 8'hFD};

    initial begin
        exp_t            e;
        int              waited;
        logic [SIZE-1:0] ra, rb;

        n_vec = 0; n_cmp = 0; n_err = 0;
        rdy_mode     = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;

        // ---------- reset state ----------
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid),    32'd0);
        check("rst_gt",        32'(bus.is_a_greater), 32'd0);
        check("rst_eq",        32'(bus.equal),        32'd0);
        check("rst_in_ready",  32'(bus.in_ready),     32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------- latency: 0x05 vs 0x03 ----------
        send(8'h05, 8'h03);
        for (int k = 1; k <= SIZE; k++) begin
            @(posedge clk);
            #1;
            check("lat_in_ready_low", 32'(bus.in_ready),  32'd0);
            check("lat_out_valid",    32'(bus.out_valid), (k == SIZE) ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        #1;
        check("lat_out_valid_drop", 32'(bus.out_valid), 32'd0);
        check("lat_in_ready_back",  32'(bus.in_ready),  32'd1);

        // ---------- sign and equality cases ----------
        for (int i = 0; i < 5; i++) send(sign_a[i], sign_b[i]);

        // ---------- backpressure ----------
        repeat (SIZE + 3) @(posedge clk);
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(8'h3C, 8'hC3);
        e = model(8'h3C, 8'hC3);
        waited = 0;
        while (!bus.out_valid && waited < 50) begin
            @(posedge clk);
            #2;
            waited++;
        end
        check("bp_out_valid_seen", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                bus.in_valid = 1'b1;
                bus.a        = 8'h00;
                bus.b        = 8'h55;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #2;
            check("bp_out_valid_hold", 32'(bus.out_valid),    32'd1);
            check("bp_in_ready_low",   32'(bus.in_ready),     32'd0);
            check("bp_gt_stable",      32'(bus.is_a_greater), 32'(e.gt));
            check("bp_eq_stable",      32'(bus.equal),        32'(e.eq));
        end
        bus.in_valid = 1'b0;
        rdy_mode = 0;
        waited = 0;
        while (!bus.out_ready && waited < 10) begin
            @(posedge clk);
            #2;
            waited++;
        end
        @(posedge clk);
        #2;
        check("bp_out_valid_drop", 32'(bus.out_valid), 32'd0);
        check("bp_in_ready_back",  32'(bus.in_ready),  32'd1);
        repeat (SIZE + 2) @(posedge clk);
        #2;
        check("bp_pulse_ignored", 32'(bus.out_valid), 32'd0);

        // ---------- reset mid-scan ----------
        @(posedge clk);
        #1;
        send(8'h5A, 8'h5A);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid),    32'd0);
        check("mid_rst_gt",        32'(bus.is_a_greater), 32'd0);
        check("mid_rst_eq",        32'(bus.equal),        32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),     32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'h10, 8'h10);

        // ---------- random vectors with random stalls ----------
        rdy_mode = 1;
        repeat (3000) begin
            case ($urandom_range(7))
                0:       begin ra = SIZE'($urandom); rb = ra; end
                1:       begin ra = 8'h80; rb = SIZE'($urandom); end
                2:       begin ra = SIZE'($urandom); rb = 8'h7F; end
                default: begin ra = SIZE'($urandom); rb = SIZE'($urandom); end
            endcase
            send(ra, rb);
        end

        // ---------- drain ----------
        rdy_mode = 0;
        waited = 0;
        while (exp_q.size() != 0 && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("checks performed: %0d", n_cmp);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_serial_signed_comparator

// File: doc/serial_signed_comparator.md
Name: serial_signed_comparator

Overview:
- Bit-serial, LSB-first signed two's-complement comparator for the ALU's low-area compare path.
- Takes SIZE-bit operands through a valid/ready handshake and scans one bit per clock, starting at bit 0.
- Returns is_a_greater and equal flags through a second valid/ready handshake.
- Flag results match the parallel signed comparator bit-for-bit; it trades latency for area.

Parameters:
- SIZE, 8, operand width in bits including sign bit; legal range SIZE >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands.
- a  input  SIZE  operand A, two's complement.
- b  input  SIZE  operand B, two's complement.
- out_valid  output  1  result flags valid.
- out_ready  input  1  consumer accepts result.
- is_a_greater  output  1  1 when signed a > signed b.
- equal  output  1  1 when a == b.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, any state, including mid-scan): state=IDLE, out_valid=0, is_a_greater=0, equal=0, bit counter=0, shift registers=0. Any in-flight operation is discarded.
- in_ready = (state==IDLE), combinational from state only. No combinational path from in_valid or out_ready to any output.
- FSM states IDLE, SHIFT, DONE.
- IDLE:
  - On in_valid&&in_ready, capture a and b into shift registers.
  - Set running gt=0, eq=1, counter=0; go to SHIFT.
- SHIFT, each cycle examines a_sr[0], b_sr[0], then shifts both registers right by 1 and increments the counter.
  - Bits 0..SIZE-2: if bits differ, gt<=a bit, eq<=0. Else gt and eq hold. A later (more significant) difference overrides an earlier one.
  - Bit SIZE-1 (sign), when counter==SIZE-1: if bits differ, gt<=~a bit, eq<=0. Then go to DONE.
- DONE:
  - out_valid=1. is_a_greater=gt and equal=eq, registered and stable while out_valid is high.
  - On out_ready, go to IDLE: out_valid<=0 next cycle. Flags may hold their value and are don't-care while out_valid is low.
- Latency:
  - Accept edge E0; edges E1..E_SIZE perform the scan.
  - out_valid is high from E_SIZE, i.e. SIZE cycles after acceptance.
  - Minimum initiation interval is SIZE+2 cycles (accept, SIZE scan cycles, one handshake cycle).
- Backpressure: DONE holds indefinitely until out_ready. in_ready stays 0 and new operands are not sampled.
- out_ready while out_valid=0 is ignored. in_valid outside IDLE is ignored; the source must hold a/b until the transfer.
- Invariants:
  - equal=1 implies is_a_greater=0.
  - Counter width is $clog2(SIZE). Counter never exceeds SIZE-1 and never wraps.
- Sign handling: sign-bit difference always dominates. For equal signs, the remaining bits compare as unsigned, which is correct for two's complement in both signs.

Decomposition:
- Shared package comparator_pkg holds:
  - cmp_state_t enum {CMP_IDLE, CMP_SHIFT, CMP_DONE};
  - localparam helper CMP_CNT_W(SIZE) = $clog2(SIZE).
- One natural combinational sub-module: compare_bit_step.
  - Inputs: a_bit, b_bit, is_sign, gt_in, eq_in. Outputs: gt_out, eq_out.
  - Implements the per-bit update rule above and is reusable by other serial ALU ops.
- FSM, counter and shift registers stay in the top module.

Test Plan (SIZE=8):
- a=0x05, b=0x03, out_ready=1 -> out_valid high exactly 8 cycles after accept, is_a_greater=1, equal=0. in_ready low throughout, high again the cycle after the result handshake.
- Sign cases:
  - a=0xFF (-1), b=0x01 -> is_a_greater=0, equal=0.
  - a=0x7F, b=0x80 -> is_a_greater=1, equal=0.
  - a=0x80, b=0x7F -> is_a_greater=0, equal=0.
- a=b=0xA5 -> equal=1, is_a_greater=0. Then a=0xFE (-2), b=0xFD (-3) -> is_a_greater=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> flags stable, in_ready=0, a pulsed in_valid is ignored. Then out_ready=1 -> out_valid drops next cycle.
- Reset mid-scan: drop rst_n 3 cycles into SHIFT -> out_valid, is_a_greater and equal go 0 immediately (asynchronously), state=IDLE. After release, a=0x10, b=0x10 -> equal=1.
- Exhaustive sweep of all 65536 a/b pairs against a signed reference model with random out_ready stalls -> zero mismatches.
